mult16_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one combinational Booth radix-4 / Wallace-tree 16x16 signed multiplier between two requesters. It accepts operand pairs over valid/ready, registers the granted pair in front of the multiplier, captures the 32-bit product into a per-port response slot, and returns it over valid/ready. It sits between the requesting datapaths and the multiplier core, and owns all sequencing, fairness and backpressure.

---
 rtl/mult16_pkg.sv | 28 ++
 rtl/booth4_wallace_mult16_16.sv | 38 +++
 rtl/mult16_arbiter.sv | 113 +++++++++++
 tb/tb_mult16_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult16_pkg.sv
// Shared widths, port identifiers and the carry-save helper for the
// two-port multiplier arbiter and its Booth/Wallace core.
package mult16_pkg;
  localparam int OPW      = 16;
  localparam int PRODW    = 32;
  localparam int PORT_IDW = 1;

  typedef logic [PORT_IDW-1:0] port_id_t;

  localparam port_id_t PORT0 = 1'b0;
  localparam port_id_t PORT1 = 1'b1;

  typedef struct packed {
    logic [PRODW-1:0] sum;
    logic [PRODW-1:0] carry;
  } csa_t;

  // 3:2 compressor across the full product width; carry-out of bit 31 is
  // dropped, which is exact for a modulo-2^32 signed product.
  function automatic csa_t csa3(input logic [PRODW-1:0] x,
                                input logic [PRODW-1:0] y,
                                input logic [PRODW-1:0] z);
    csa_t r;
    r.sum   = x ^ y ^ z;
    r.carry = ((x & y) | (x & z) | (y & z)) << 1;
    return r;
  endfunction
endpackage

// File: rtl/booth4_wallace_mult16_16.sv
// Combinational signed 16x16 multiplier: radix-4 Booth partial products
// reduced by a Wallace tree of 3:2 compressors and one final adder.
module booth4_wallace_mult16_16
  import mult16_pkg::*;
(
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [31:0] P
);
  logic [PRODW-1:0] a_ext;
  logic [16:0]      b_ext;
  logic [PRODW-1:0] pp [8];
  csa_t             l1a, l1b, l2a, l2b, l3, l4;

  assign a_ext = {{16{A[15]}}, A};
  assign b_ext = {B, 1'b0};

  // Each overlapping 3-bit group of B selects 0, +-A or +-2A at weight 4^i.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: pp[i] = a_ext << (2*i);
        3'b011:         pp[i] = a_ext << (2*i + 1);
        3'b100:         pp[i] = ~(a_ext << (2*i + 1)) + 32'd1;
        3'b101, 3'b110: pp[i] = ~(a_ext << (2*i)) + 32'd1;
        default:        pp[i] = '0;
      endcase
    end
  end

  assign l1a = csa3(pp[0], pp[1], pp[2]);
  assign l1b = csa3(pp[3], pp[4], pp[5]);
  assign l2a = csa3(l1a.sum, l1a.carry, l1b.sum);
  assign l2b = csa3(l1b.carry, pp[6], pp[7]);
  assign l3  = csa3(l2a.sum, l2a.carry, l2b.sum);
  assign l4  = csa3(l3.sum, l3.carry, l2b.carry);
  assign P   = l4.sum + l4.carry;
endmodule

// File: rtl/mult16_arbiter.sv
// Two-port round-robin front end sharing one signed 16x16 multiplier:
// one registered operand stage, one response slot per port.
module mult16_arbiter
  import mult16_pkg::*;
#(
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        busy
);
  // Handshake: a transfer happens on the rising edge where valid && ready.
  // req_p_ready never looks at req_p_valid; rsp_p_valid never looks at rsp_p_ready.
  logic [1:0]                  req_valid, req_ready, rsp_ready;
  logic [1:0]                  rsp_hs, slot_free, elig, contend, grant, s1_done;
  logic [1:0]                  rsp_valid_q, rsp_valid_d;
  logic [1:0][PRODW-1:0]       rsp_data_q, rsp_data_d;
  logic                        s1_vld_q, s1_vld_d;
  port_id_t                    s1_id_q, s1_id_d;
  logic [OPW-1:0]              s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  port_id_t                    prio_q, prio_d;
  logic [PRODW-1:0]            prod;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  assign s1_done[0] = s1_vld_q & (s1_id_q == PORT0);
  assign s1_done[1] = s1_vld_q & (s1_id_q == PORT1);
  assign rsp_hs     = rsp_valid_q & rsp_ready;
  assign slot_free  = ~rsp_valid_q | rsp_hs;
  // One op per port in flight: a port whose op sits in stage 1 must wait.
  assign elig       = slot_free & ~s1_done;
  assign contend    = elig & req_valid;

  assign req_ready[0] = elig[0] & ~(contend[1] & (prio_q == PORT1));
  assign req_ready[1] = elig[1] & ~(contend[0] & (prio_q == PORT0));
  assign grant        = req_ready & req_valid;

  always_comb begin
    s1_vld_d = |grant;
    s1_id_d  = grant[1] ? PORT1 : PORT0;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (grant[1]) begin
      s1_a_d = req1_a;
      s1_b_d = req1_b;
    end else if (grant[0]) begin
      s1_a_d = req0_a;
      s1_b_d = req0_b;
    end
    prio_d = (|grant) ? ~s1_id_d : prio_q;
  end

  booth4_wallace_mult16_16 u_mult (
    .A(s1_a_q),
    .B(s1_b_q),
    .P(prod)
  );

  // A completing product refills its slot even if the old one drains this edge.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_hs;
    rsp_data_d  = rsp_data_q;
    for (int p = 0; p < 2; p++) begin
      if (s1_done[p]) begin
        rsp_valid_d[p] = 1'b1;
        rsp_data_d[p]  = prod;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1_vld_q    <= 1'b0;
      s1_id_q     <= PORT0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      prio_q      <= port_id_t'(FIRST_PRIO);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      s1_vld_q    <= s1_vld_d;
      s1_id_q     <= s1_id_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      prio_q      <= prio_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp_data_q[0];
  assign rsp1_data  = rsp_data_q[1];
  assign busy       = s1_vld_q | (|rsp_valid_q);
endmodule

// File: tb/tb_mult16_arbiter.sv
// Directed and soak bench for mult16_arbiter: per-scenario tasks with inline
// checks, a per-port expected-product queue and one summary line.
module tb_mult16_arbiter;
  localparam bit FIRST_PRIO = 1'b1;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic [1:0]       req_valid, rsp_ready;
  logic [1:0][15:0] req_a, req_b;
  wire  [1:0]       req_ready, rsp_valid;
  wire  [1:0][31:0] rsp_data;
  wire              busy;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [1:0]  infl, done_, acc_now;
  int          acc_cnt [2];

  mult16_arbiter #(.FIRST_PRIO(FIRST_PRIO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req0_valid(req_valid[0]),
    .req0_ready(req_ready[0]),
    .req0_a    (req_a[0]),
    .req0_b    (req_b[0]),
    .req1_valid(req_valid[1]),
    .req1_ready(req_ready[1]),
    .req1_a    (req_a[1]),
    .req1_b    (req_b[1]),
    .rsp0_valid(rsp_valid[0]),
    .rsp0_ready(rsp_ready[0]),
    .rsp0_data (rsp_data[0]),
    .rsp1_valid(rsp_valid[1]),
    .rsp1_ready(rsp_ready[1]),
    .rsp1_data (rsp_data[1]),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] sa, sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    sys_rst   = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    infl       = 2'b00;
    done_      = 2'b00;
    acc_now    = 2'b00;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
  endtask

  // ---------------- scoreboard (called once per cycle at negedge) ----------------
  task automatic sb_sample();
    logic [31:0] exp;
    int          qsz;
    for (int p = 0; p < 2; p++) begin
      if (done_[p]) begin
        checks++;
        if (rsp_valid[p] !== 1'b1) begin
          errors++;
          $display("FAIL rsp_latency port%0d: rsp_valid=%b expected 1", p, rsp_valid[p]);
        end
      end
      if (infl[p]) begin
        checks++;
        if (req_ready[p] !== 1'b0 || (rsp_valid[p] === 1'b1 && rsp_ready[p])) begin
          errors++;
          $display("FAIL in_flight port%0d: req_ready=%b rsp_valid=%b rsp_ready=%b expected req_ready=0 and no rsp handshake",
                   p, req_ready[p], rsp_valid[p], rsp_ready[p]);
        end
      end
      if (rsp_valid[p] === 1'b1 && rsp_ready[p]) begin
        checks++;
        qsz = (p == 0) ? exp_q0.size() : exp_q1.size();
        if (qsz == 0) begin
          errors++;
          $display("FAIL spurious_rsp port%0d: data=%h with no outstanding request", p, rsp_data[p]);
        end else begin
          if (p == 0) exp = exp_q0.pop_front();
          else        exp = exp_q1.pop_front();
          if (rsp_data[p] !== exp) begin
            errors++;
            $display("FAIL rsp_data port%0d: got %h expected %h", p, rsp_data[p], exp);
          end
        end
      end
      acc_now[p] = req_valid[p] && (req_ready[p] === 1'b1);
      if (acc_now[p]) begin
        acc_cnt[p]++;
        if (p == 0) exp_q0.push_back(ref_mul(req_a[0], req_b[0]));
        else        exp_q1.push_back(ref_mul(req_a[1], req_b[1]));
      end
      done_[p] = infl[p];
      infl[p]  = acc_now[p];
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_data[0] !== 32'h0) begin errors++; $display("FAIL reset_rsp0_data: got %h expected 0", rsp_data[0]); end
    checks++; if (rsp_data[1] !== 32'h0) begin errors++; $display("FAIL reset_rsp1_data: got %h expected 0", rsp_data[1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    checks++; if (req_ready !== 2'b11) begin errors++; $display("FAIL idle_ready: got %b expected 11", req_ready); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_single_op();
    rsp_ready    = 2'b11;
    req_a[0]     = 16'd3;
    req_b[0]     = 16'hFFFB;
    req_valid[0] = 1'b1;
    @(negedge sys_clk);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", req_ready[0]); end
    @(posedge sys_clk); #1;
    req_valid[0] = 1'b0;
    @(negedge sys_clk);
    checks++; if (rsp_valid[0] !== 1'b0) begin errors++; $display("FAIL single_early: rsp0_valid=%b expected 0", rsp_valid[0]); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    checks++; if (req_ready[0] !== 1'b0) begin errors++; $display("FAIL single_inflight_ready: got %b expected 0", req_ready[0]); end
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", rsp_valid[0]); end
    checks++; if (rsp_data[0] !== 32'hFFFF_FFF1) begin errors++; $display("FAIL single_data: got %h expected fffffff1", rsp_data[0]); end
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL single_other: rsp1_valid=%b expected 0", rsp_valid[1]); end
    @(posedge sys_clk); #1;
    @(negedge sys_clk);
    checks++; if (rsp_valid[0] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drain: rsp0_valid=%b busy=%b expected 0 0", rsp_valid[0], busy); end
    @(posedge sys_clk); #1;
  endtask

  task automatic test_corners();
    logic [15:0] ta [10];
    logic [15:0] tb_v [10];
    logic [31:0] te [10];
    int p;
    ta   = '{16'h0003, 16'h8000, 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h04D2, 16'h0064, 16'hFED4};
    tb_v = '{16'hFFFB, 16'h8000, 16'h7FFF, 16'h04D2, 16'h7FFF, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h00C8, 16'h0007};
    te   = '{32'hFFFF_FFF1, 32'h4000_0000, 32'hC000_8000, 32'h0000_0000, 32'h3FFF_0001,
             32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FB2E, 32'h0000_4E20, 32'hFFFF_F7CC};
    rsp_ready = 2'b11;
    for (int i = 0; i < 10; i++) begin
      p = i % 2;
      req_a[p]     = ta[i];
      req_b[p]     = tb_v[i];
      req_valid[p] = 1'b1;
      @(negedge sys_clk);
      checks++; if (req_ready[p] !== 1'b1) begin errors++; $display("FAIL corner%0d_ready: got %b expected 1", i, req_ready[p]); end
      @(posedge sys_clk); #1;
      req_valid[p] = 1'b0;
      @(posedge sys_clk); #1;
      @(negedge sys_clk);
      checks++;
      if (rsp_valid[p] !== 1'b1 || rsp_data[p] !== te[i]) begin
        errors++;
        $display("FAIL corner%0d_data port%0d: valid=%b data=%h expected 1 %h", i, p, rsp_valid[p], rsp_data[p], te[i]);
      end
      checks++; if (rsp_data[p] !== ref_mul(ta[i], tb_v[i])) begin errors++; $display("FAIL corner%0d_model: got %h expected %h", i, rsp_data[p], ref_mul(ta[i], tb_v[i])); end
      checks++; if (rsp_valid[1-p] !== 1'b0) begin errors++; $display("FAIL corner%0d_other: valid=%b expected 0", i, rsp_valid[1-p]); end
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic test_contention();
    int g;
    apply_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      req_a[0] = 16'(100 + i);
      req_b[0] = 16'(i - 5);
      req_a[1] = 16'(-200 - i);
      req_b[1] = 16'(300 + 7 * i);
      @(negedge sys_clk);
      g = (i % 2 == 0) ? int'(FIRST_PRIO) : 1 - int'(FIRST_PRIO);
      checks++;
      if (req_ready !== (2'b01 << g)) begin
        errors++;
        $display("FAIL contention_grant cycle%0d: req_ready=%b expected grant to port%0d", i, req_ready, g);
      end
      sb_sample();
      @(posedge sys_clk); #1;
    end
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk); sb_sample();
      @(posedge sys_clk); #1;
    end
    checks++; if (acc_cnt[0] != 5 || acc_cnt[1] != 5) begin errors++; $display("FAIL contention_count: accepts %0d/%0d expected 5/5", acc_cnt[0], acc_cnt[1]); end
    checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin errors++; $display("FAIL contention_drain: outstanding %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size()); end
  endtask

  task automatic test_backpressure();
    int p1_base;
    apply_reset();
    rsp_ready    = 2'b10;
    req_a[0]     = 16'h04D2;
    req_b[0]     = 16'hFFFF;
    req_valid[0] = 1'b1;
    @(negedge sys_clk); sb_sample();
    @(posedge sys_clk); #1;
    req_a[0] = 16'd7;
    req_b[0] = 16'd9;
    req_valid[1] = 1'b1;
    p1_base = acc_cnt[1];
    for (int k = 0; k < 8; k++) begin
      req_a[1] = 16'(k * 3 + 1);
      req_b[1] = 16'(-(k * 11) - 2);
      @(negedge sys_clk);
      if (k >= 1) begin
        checks++;
        if (req_ready[0] !== 1'b0 || rsp_valid[0] !== 1'b1 || rsp_data[0] !== 32'hFFFF_FB2E) begin
          errors++;
          $display("FAIL stall_hold cycle%0d: req0_ready=%b rsp0_valid=%b rsp0_data=%h expected 0 1 fffffb2e",
                   k, req_ready[0], rsp_valid[0], rsp_data[0]);
        end
      end
      sb_sample();
      @(posedge sys_clk); #1;
    end
    checks++; if (acc_cnt[1] - p1_base != 4) begin errors++; $display("FAIL stall_port1_rate: %0d accepts in 8 cycles expected 4", acc_cnt[1] - p1_base); end
    rsp_ready[0] = 1'b1;
    @(negedge sys_clk);
    checks++; if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL stall_reenable: req0_ready=%b expected 1", req_ready[0]); end
    sb_sample();
    @(posedge sys_clk); #1;
    req_valid = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk); sb_sample();
      @(posedge sys_clk); #1;
    end
    checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin errors++; $display("FAIL stall_drain: outstanding %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size()); end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    rsp_ready    = 2'b00;
    req_a[0]     = 16'h8000;
    req_b[0]     = 16'h8000;
    req_valid[0] = 1'b1;
    @(posedge sys_clk); #1;
    req_valid[0] = 1'b0;
    req_a[1]     = 16'd5;
    req_b[1]     = 16'd5;
    req_valid[1] = 1'b1;
    @(posedge sys_clk); #1;
    req_valid[1] = 1'b0;
    checks++; if (rsp_valid[0] !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midflight_setup: rsp0_valid=%b busy=%b expected 1 1", rsp_valid[0], busy); end
    sys_rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL midflight_valid: got %b expected 00", rsp_valid); end
    checks++; if (rsp_data[0] !== 32'h0 || rsp_data[1] !== 32'h0) begin errors++; $display("FAIL midflight_data: got %h %h expected 0 0", rsp_data[0], rsp_data[1]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midflight_busy: got %b expected 0", busy); end
    @(posedge sys_clk); #1;
    sys_rst   = 1'b0;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge sys_clk);
      checks++; if (rsp_valid !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL midflight_ghost cycle%0d: rsp_valid=%b busy=%b expected 00 0", k, rsp_valid, busy); end
      @(posedge sys_clk); #1;
    end
    req_valid = 2'b11;
    @(negedge sys_clk);
    checks++; if (req_ready !== (2'b01 << FIRST_PRIO)) begin errors++; $display("FAIL midflight_first_grant: req_ready=%b expected grant to port%0d", req_ready, FIRST_PRIO); end
    @(posedge sys_clk); #1;
    req_valid = 2'b00;
    repeat (3) begin @(posedge sys_clk); #1; end
  endtask

  task automatic test_random_soak();
    int   total;
    int   p;
    logic r;
    apply_reset();
    total = 0;
    for (int cyc = 0; cyc < 30000 && total < 10000; cyc++) begin
      for (int q = 0; q < 2; q++) begin
        if (!req_valid[q] || acc_now[q]) begin
          req_valid[q] = ($urandom_range(0, 3) != 0);
          req_a[q]     = rand16();
          req_b[q]     = rand16();
        end
        rsp_ready[q] = ($urandom_range(0, 3) != 0);
      end
      @(negedge sys_clk);
      sb_sample();
      total = acc_cnt[0] + acc_cnt[1];
      if (cyc % 16 == 0) begin
        p = (cyc / 16) % 2;
        r = req_ready[p];
        req_valid[p] = ~req_valid[p];
        #1;
        checks++; if (req_ready[p] !== r) begin errors++; $display("FAIL ready_on_valid port%0d: ready %b became %b when valid toggled", p, r, req_ready[p]); end
        req_valid[p] = ~req_valid[p];
        #1;
      end
      @(posedge sys_clk); #1;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk); sb_sample();
      @(posedge sys_clk); #1;
    end
    checks++; if (total < 10000) begin errors++; $display("FAIL soak_progress: %0d accepts expected 10000", total); end
    checks++; if (exp_q0.size() != 0 || exp_q1.size() != 0) begin errors++; $display("FAIL soak_drain: outstanding %0d/%0d expected 0/0", exp_q0.size(), exp_q1.size()); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_a     = '0;
    req_b     = '0;
    infl      = 2'b00;
    done_     = 2'b00;
    acc_now   = 2'b00;
    test_reset();
    test_single_op();
    test_corners();
    test_contention();
    test_backpressure();
    test_reset_midflight();
    test_random_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
